// File: rtl/mmio_timer_port_if.sv
// mmio_timer_port_if
//   Processor data-memory bus as seen by one memory-mapped peripheral.
//   addr  : 16-bit data-memory address (master -> slave)
//   wdata : 16-bit write data          (master -> slave)
//   write : write enable, taken at the rising clock edge (master -> slave)
//   read  : read enable                (master -> slave)
//   rdata : 16-bit combinational read data; 0 when not selected (slave -> master)
//   hit   : peripheral claims the access, so the data memory stays quiet (slave -> master)
interface mmio_timer_port_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        write;
  logic        read;
  logic [15:0] rdata;
  logic        hit;

  modport master (
    output addr, wdata, write, read,
    input  rdata, hit
  );

  modport slave (
    input  addr, wdata, write, read,
    output rdata, hit
  );
endinterface

// File: rtl/mmio_timer_port.sv
// mmio_timer_port
//   Four-word memory-mapped peripheral: a hex digit driving a 7-segment
//   display, two debounced switches, and a prescaled down-counting timer
//   with a sticky done flag.
//
//   Register window (addr[15:2] == BASE[15:2]):
//     offset 0 DIGIT  : R/W, low nibble drives the display
//     offset 1 SWITCH : RO,  {14'b0, sw1_db, sw0_db}
//     offset 2 COUNT  : R/W, write loads and (re)starts the timer
//     offset 3 STATUS : R,   {14'b0, running, done}; any write clears done
//
//   Ports:
//     clock   : sole clock, rising edge
//     reset   : asynchronous, active-high
//     bus     : processor bus (slave side), see mmio_timer_port_if
//     sw0,sw1 : raw asynchronous switch inputs
//     display : active-low segments {g,f,e,d,c,b,a}
//     done    : sticky timer-expired flag
module mmio_timer_port #(
  parameter logic [15:0] BASE     = 16'hFFF0,
  parameter int          DEBOUNCE = 4,
  parameter int          PRESCALE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  mmio_timer_port_if.slave      bus,
  input  logic                  sw0,
  input  logic                  sw1,
  output logic [6:0]            display,
  output logic                  done
);

  localparam logic [7:0] DB_TARGET     = 8'(DEBOUNCE);
  localparam logic [7:0] PRESCALE_LAST = 8'(PRESCALE - 1);

  localparam logic [1:0] OFF_DIGIT  = 2'd0;
  localparam logic [1:0] OFF_SWITCH = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic       in_window;
  logic [1:0] offset;
  logic       wr_digit;
  logic       wr_count;
  logic       wr_status;

  assign in_window = (bus.addr[15:2] == BASE[15:2]);
  assign offset    = bus.addr[1:0];
  assign bus.hit   = (bus.read | bus.write) & in_window;
  assign wr_digit  = bus.write & in_window & (offset == OFF_DIGIT);
  assign wr_count  = bus.write & in_window & (offset == OFF_COUNT);
  assign wr_status = bus.write & in_window & (offset == OFF_STATUS);

  // ------------------------------------------------------------------
  // Digit register and 7-segment decode
  // ------------------------------------------------------------------
  logic [3:0] digit_reg;
  logic [6:0] display_reg;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_reg <= 4'h0;
    end else if (wr_digit) begin
      digit_reg <= bus.wdata[3:0];
    end
  end

  // Decoded from the stored digit only, so the display lags a write by one
  // edge but never glitches on bus activity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      display_reg <= 7'b1000000;
    end else begin
      display_reg <= seg_decode(digit_reg);
    end
  end

  assign display = display_reg;

  // ------------------------------------------------------------------
  // Switch synchronizers and debouncers, one lane per switch
  // ------------------------------------------------------------------
  logic [1:0] sw_raw;
  logic [1:0] sw_db;

  assign sw_raw = {sw1, sw0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sw
      logic       sync1_reg;
      logic       sync2_reg;
      logic       db_reg;
      logic [7:0] cnt_reg;
      logic [7:0] cnt_inc;

      assign cnt_inc = cnt_reg + 8'd1;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          db_reg    <= 1'b0;
          cnt_reg   <= 8'd0;
        end else begin
          sync1_reg <= sw_raw[gi];
          sync2_reg <= sync1_reg;
          // Count consecutive samples that disagree with the accepted level;
          // a single agreeing sample throws the partial count away.
          if (sync2_reg != db_reg) begin
            if (cnt_inc == DB_TARGET) begin
              db_reg  <= sync2_reg;
              cnt_reg <= 8'd0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end else begin
            cnt_reg <= 8'd0;
          end
        end
      end

      assign sw_db[gi] = db_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Prescaled down-counter
  // ------------------------------------------------------------------
  logic [15:0] count_reg;
  logic [15:0] count_next;
  logic [7:0]  presc_reg;
  logic [7:0]  presc_next;
  logic        done_reg;
  logic        done_next;
  logic        set_done;
  logic        running;

  assign running = (count_reg != 16'd0);

  // A COUNT write overrides whatever the timer would have done this edge,
  // including the final 1->0 step, so a reload at that instant sets no done.
  always_comb begin
    count_next = count_reg;
    presc_next = presc_reg;
    set_done   = 1'b0;
    if (wr_count) begin
      count_next = bus.wdata;
      presc_next = 8'd0;
    end else if (running) begin
      if (presc_reg == PRESCALE_LAST) begin
        presc_next = 8'd0;
        count_next = count_reg - 16'd1;
        set_done   = (count_reg == 16'd1);
      end else begin
        presc_next = presc_reg + 8'd1;
      end
    end
  end

  // Setting beats a same-edge STATUS clear so an expiry is never lost.
  always_comb begin
    done_next = done_reg;
    if (set_done) begin
      done_next = 1'b1;
    end else if (wr_status) begin
      done_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= 16'd0;
      presc_reg <= 8'd0;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      presc_reg <= presc_next;
      done_reg  <= done_next;
    end
  end

  assign done = done_reg;

  // ------------------------------------------------------------------
  // Read mux: purely combinational from current state, so a same-cycle
  // write is seen only after the edge.
  // ------------------------------------------------------------------
  logic [15:0] rdata_mux;

  always_comb begin
    rdata_mux = 16'h0000;
    if (bus.read && in_window) begin
      case (offset)
        OFF_DIGIT:  rdata_mux = {12'h000, digit_reg};
        OFF_SWITCH: rdata_mux = {14'b0, sw_db};
        OFF_COUNT:  rdata_mux = count_reg;
        OFF_STATUS: rdata_mux = {14'b0, running, done_reg};
        default:    rdata_mux = 16'h0000;
      endcase
    end
  end

  assign bus.rdata = rdata_mux;

endmodule

// File: tb/tb_mmio_timer_port.sv
// tb_mmio_timer_port
//   Directed bench for mmio_timer_port with default parameters
//   (BASE=FFF0, DEBOUNCE=4, PRESCALE=4). Inputs change on the falling edge,
//   outputs are sampled on the falling edge or shortly after an input change.
module tb_mmio_timer_port;
  logic       clock;
  logic       reset;
  logic       sw0;
  logic       sw1;
  logic [6:0] display;
  logic       done;

  int checks;
  int passed;

  mmio_timer_port_if bus ();

  mmio_timer_port dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .sw0     (sw0),
    .sw1     (sw1),
    .display (display),
    .done    (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance exactly one rising edge, return on the following falling edge.
  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %-16s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.write = 1'b0;
    bus.read  = 1'b0;
    bus.addr  = 16'h0000;
    bus.wdata = 16'h0000;
  endtask

  // One-edge write, bus idle afterwards.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.write = 1'b1;
    bus.read  = 1'b0;
    cycle();
    bus_idle();
  endtask

  // Combinational read: drive, settle, return.
  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.addr  = a;
    bus.read  = 1'b1;
    bus.write = 1'b0;
    #1;
    d = bus.rdata;
  endtask

  logic [15:0] v;

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    sw0    = 1'b0;
    sw1    = 1'b0;
    bus_idle();

    // ---------------- reset state, write ignored during reset ----------
    cycle(2);
    chk("rst_display", {9'd0, display}, 16'h0040);
    chk("rst_done", {15'd0, done}, 16'h0000);
    bus.addr  = 16'hFFF0;
    bus.wdata = 16'h0009;
    bus.write = 1'b1;
    #1;
    chk("rst_hit_comb", {15'd0, bus.hit}, 16'h0001);
    cycle();
    bus_idle();
    rd(16'hFFF0, v);
    chk("rst_wr_ignored", v, 16'h0000);
    bus_idle();
    reset = 1'b0;
    cycle();

    // ---------------- DIGIT ------------------------------------------
    wr(16'hFFF0, 16'h0008);
    cycle();
    chk("display_8", {9'd0, display}, 16'h0000);
    rd(16'hFFF0, v);
    chk("digit_rd_8", v, 16'h0008);
    chk("digit_hit", {15'd0, bus.hit}, 16'h0001);
    bus_idle();
    wr(16'hFFF0, 16'hABCF);
    cycle();
    chk("display_F", {9'd0, display}, 16'h000E);
    wr(16'h0010, 16'h0003);
    cycle();
    rd(16'hFFF0, v);
    chk("outside_wr", v, 16'h000F);
    bus_idle();

    // ---------------- SWITCH debounce ----------------------------------
    sw1 = 1'b1;
    cycle(5);                       // 1+DEBOUNCE edges: not yet accepted
    rd(16'hFFF1, v);
    chk("sw1_early", v, 16'h0000);
    cycle();                        // 2+DEBOUNCE edges
    rd(16'hFFF1, v);
    chk("sw1_accepted", v, 16'h0002);
    bus_idle();
    wr(16'hFFF1, 16'h0001);
    rd(16'hFFF1, v);
    chk("sw_wr_ignored", v, 16'h0002);
    bus_idle();
    sw0 = 1'b1;
    cycle(2);
    sw0 = 1'b0;
    cycle(8);
    rd(16'hFFF1, v);
    chk("sw0_glitch", v, 16'h0002);
    bus_idle();

    // ---------------- COUNT = 3 --------------------------------------
    wr(16'hFFF2, 16'h0003);         // write edge already taken
    rd(16'hFFF3, v);
    chk("status_running", v, 16'h0002);
    bus.addr = 16'hFFF2;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      #1;
      if (i == 3)  chk("count_3", bus.rdata, 16'h0003);
      if (i == 4)  chk("count_2", bus.rdata, 16'h0002);
      if (i == 8)  chk("count_1", bus.rdata, 16'h0001);
      if (i == 11) chk("done_early", {15'd0, done}, 16'h0000);
      if (i == 12) chk("count_0", bus.rdata, 16'h0000);
      if (i == 12) chk("done_12", {15'd0, done}, 16'h0001);
    end
    cycle(4);
    rd(16'hFFF2, v);
    chk("count_no_wrap", v, 16'h0000);
    rd(16'hFFF3, v);
    chk("status_done", v, 16'h0001);
    bus_idle();

    // ---------------- STATUS clear, zero load ------------------------
    wr(16'hFFF3, 16'h0000);
    chk("done_cleared", {15'd0, done}, 16'h0000);
    wr(16'hFFF2, 16'h0000);
    cycle(6);
    chk("zero_load_done", {15'd0, done}, 16'h0000);
    rd(16'hFFF3, v);
    chk("zero_load_stat", v, 16'h0000);
    bus_idle();

    // ---------------- set beats clear on the same edge ----------------
    wr(16'hFFF2, 16'h0001);
    cycle(3);
    wr(16'hFFF3, 16'h0000);         // lands on the expiry edge
    chk("set_wins", {15'd0, done}, 16'h0001);

    // ---------------- reload beats decrement -------------------------
    wr(16'hFFF2, 16'h0002);
    cycle(3);
    wr(16'hFFF2, 16'h0005);         // lands on the decrement edge
    rd(16'hFFF2, v);
    chk("reload_prio", v, 16'h0005);
    bus.write = 1'b1;
    bus.wdata = 16'h0007;
    #1;
    chk("rw_pre_value", bus.rdata, 16'h0005);
    cycle();
    bus.write = 1'b0;
    #1;
    chk("rw_post_value", bus.rdata, 16'h0007);
    bus_idle();

    // ---------------- outside window ---------------------------------
    rd(16'h0010, v);
    chk("out_rdata", v, 16'h0000);
    chk("out_hit", {15'd0, bus.hit}, 16'h0000);
    bus_idle();

    // ---------------- reset mid-count --------------------------------
    wr(16'hFFF2, 16'h0005);
    cycle(2);
    reset = 1'b1;
    rd(16'hFFF2, v);
    chk("rst_count", v, 16'h0000);
    chk("rst_done_clr", {15'd0, done}, 16'h0000);
    rd(16'hFFF0, v);
    chk("rst_digit", v, 16'h0000);
    bus_idle();
    cycle();
    chk("rst_display2", {9'd0, display}, 16'h0040);
    reset = 1'b0;
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        cycle();
        if (done) seen_done = 1'b1;
      end
      chk("no_done_post", {15'd0, seen_done}, 16'h0000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mmio_timer_port.md
MMIO_TIMER_PORT -- requirements
Module: mmio_timer_port

Interface
REQ-001 The block SHALL have parameter BASE, default 16'hFFF0, giving the 4-word register window base; bits [1:0] SHALL be ignored.
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, giving the consecutive stable synchronized samples needed to accept a switch change (range 1-255).
REQ-003 The block SHALL have parameter PRESCALE, default 4, giving the clock cycles per timer decrement (range 1-255).
REQ-004 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 addr  in  16  processor data-memory address.
REQ-007 wdata  in  16  processor write data.
REQ-008 write  in  1  write enable, sampled at the rising clock edge.
REQ-009 read  in  1  read enable.
REQ-010 sw0, sw1  in  1 each  raw asynchronous switch inputs.
REQ-011 rdata  out  16  read data, combinational.
REQ-012 hit  out  1  high when (read|write) and addr is inside the window; the data memory SHALL use it to suppress its own response.
REQ-013 display  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-014 done  out  1  sticky timer-expired flag.

Function
REQ-015 The window SHALL be selected when addr[15:2]==BASE[15:2]; offset addr[1:0]: 0 DIGIT, 1 SWITCH, 2 COUNT, 3 STATUS.
REQ-016 rdata SHALL be 16'h0000 when read=0 or the address is outside the window; a write outside the window SHALL have no effect.
REQ-017 DIGIT: a write SHALL store wdata[3:0]; a read SHALL return {12'h000, digit}.
REQ-018 display SHALL be the standard hex 7-seg decode of digit (0->7'b1000000, 1->7'b1111001, 8->7'b0000000, F->7'b0001110), registered from the digit register only.
REQ-019 SWITCH: sw0/sw1 SHALL each pass a 2-flop synchronizer, then a debouncer that updates its output only after DEBOUNCE consecutive synchronized samples differing from the current output; any reversion SHALL restart the count.
REQ-020 A SWITCH read SHALL return {14'b0, sw1_db, sw0_db}; writes to SWITCH SHALL be ignored.
REQ-021 COUNT: a write SHALL load count=wdata and clear the prescaler; a nonzero load SHALL start the timer, a zero load SHALL leave it idle without setting done.
REQ-022 While count!=0 the prescaler SHALL count 0..PRESCALE-1 and count SHALL decrement by 1 on each prescaler wrap.
REQ-023 When count decrements from 1 to 0, done SHALL be set on that same edge and the timer SHALL stop; count SHALL never wrap below 0.
REQ-024 A COUNT write while running SHALL reload and restart; it SHALL take priority over a same-cycle decrement.
REQ-025 A COUNT read SHALL return the current count; STATUS read SHALL return {14'b0, running, done}.
REQ-026 Any STATUS write SHALL clear done; if done is set in the same cycle, set SHALL win.
REQ-027 A read and write to the same register in one cycle SHALL return the pre-write value.

Reset
REQ-028 reset SHALL asynchronously force digit=0 (display=7'b1000000), count=0, prescaler=0, done=0, synchronizer flops and debounced outputs=0, debounce counters=0.
REQ-029 rdata and hit SHALL remain combinational during reset; writes during reset SHALL have no effect.
REQ-030 Reset asserted mid-count SHALL abort the timer with no done pulse after release.

Verification
REQ-031 Reset, then write DIGIT (addr FFF0) wdata=16'h0008 -> display=7'b0000000 next cycle; read FFF0 -> rdata=16'h0008, hit=1.
REQ-032 sw1 held 1 from cycle 10 -> SWITCH read (FFF1) returns 16'h0002 exactly 2+DEBOUNCE cycles later; a 2-cycle glitch on sw0 -> read stays 0.
REQ-033 Write COUNT (FFF2)=3 with PRESCALE=4 -> count reads 2,1,0 at 4-cycle intervals; done=1 on the 12th edge after the write; STATUS read=16'h0001.
REQ-034 Write STATUS (FFF3) -> done=0; write COUNT=0 -> done stays 0, STATUS=16'h0000.
REQ-035 Read at addr 16'h0010 with read=1 -> hit=0, rdata=0; reset asserted with count=5 -> count=0, done=0, and done stays 0 for 40 cycles after release.
